// File: rtl/sa_tile_framer_if.sv
// Stream bundle for sa_tile_framer: DMA-side input handshake and downstream
// output handshake, named from the framer's point of view.
interface sa_tile_framer_if #(
  parameter int DATA_WIDTH = 1024
);
  logic                  rts_i;
  logic                  rtr_o;
  logic                  eow_dma_i;
  logic [DATA_WIDTH-1:0] data_i;
  logic                  rtr_i;
  logic                  rts_o;
  logic [DATA_WIDTH-1:0] data_o;

  modport slave (
    input  rts_i, eow_dma_i, data_i, rtr_i,
    output rtr_o, rts_o, data_o
  );

  modport master (
    output rts_i, eow_dma_i, data_i, rtr_i,
    input  rtr_o, rts_o, data_o
  );
endinterface

// File: rtl/sa_tile_framer.sv
// Frames DMA beats into K-beat blocks (SOB/EOB in the two MSBs) for the
// systolic array, through a 2-entry skid buffer with a registered ready.
module sa_tile_framer #(
  parameter int DATA_WIDTH = 1024,
  parameter int K_WIDTH    = 16,
  parameter int NB_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start_i,
  input  logic [K_WIDTH-1:0]  cfg_k_i,
  input  logic [NB_WIDTH-1:0] cfg_nblocks_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_short_o,
  output logic [NB_WIDTH-1:0] blocks_done_o,
  sa_tile_framer_if.slave     stream
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_next;
  logic [K_WIDTH-1:0]    k_q, bc;
  logic [NB_WIDTH-1:0]   nb_q, blk_in;
  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count, count_next;
  logic                  rtr_q;
  logic                  push, pop, sob, eob, head_eob;
  logic                  last_eob_in, last_eob_out, done_next;

  assign push         = stream.rts_i & rtr_q;
  assign pop          = (count != 2'd0) & stream.rtr_i;
  assign head_eob     = mem[rd_ptr][DATA_WIDTH-1];
  assign sob          = (bc == '0);
  assign eob          = (bc == k_q - K_WIDTH'(1)) | stream.eow_dma_i;
  assign last_eob_in  = push & eob & ((blk_in + NB_WIDTH'(1)) == nb_q);
  assign last_eob_out = pop & head_eob & ((blocks_done_o + NB_WIDTH'(1)) == nb_q);

  assign busy_o        = (state != IDLE);
  assign stream.rtr_o  = rtr_q;
  assign stream.rts_o  = (count != 2'd0);
  assign stream.data_o = mem[rd_ptr];

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start_i) begin
          if (cfg_nblocks_i == '0) done_next = 1'b1;
          else                     state_next = RUN;
        end
      end
      RUN: begin
        if (last_eob_in) state_next = DRAIN;
      end
      DRAIN: begin
        if (last_eob_out) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 2'd1;
    else if (!push && pop) count_next = count - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_o        <= 1'b0;
      err_short_o   <= 1'b0;
      blocks_done_o <= '0;
      rtr_q         <= 1'b0;
      count         <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      mem[0]        <= '0;
      mem[1]        <= '0;
      k_q           <= '0;
      nb_q          <= '0;
      bc            <= '0;
      blk_in        <= '0;
    end else begin
      done_o <= done_next;
      count  <= count_next;
      // Ready is registered, so it must already leave room for the one beat
      // that can still land next cycle while it is high.
      rtr_q  <= (state_next == RUN) && (count_next <= 2'd1);

      if (state == IDLE && cfg_start_i) begin
        k_q           <= (cfg_k_i == '0) ? K_WIDTH'(1) : cfg_k_i;
        nb_q          <= cfg_nblocks_i;
        err_short_o   <= 1'b0;
        blocks_done_o <= '0;
        bc            <= '0;
        blk_in        <= '0;
      end

      if (push) begin
        mem[wr_ptr] <= {eob, sob, stream.data_i[DATA_WIDTH-3:0]};
        wr_ptr      <= ~wr_ptr;
        bc          <= eob ? '0 : bc + K_WIDTH'(1);
        if (eob) blk_in <= blk_in + NB_WIDTH'(1);
        if (stream.eow_dma_i && (bc != k_q - K_WIDTH'(1))) err_short_o <= 1'b1;
      end

      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (head_eob) blocks_done_o <= blocks_done_o + NB_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_sa_tile_framer.sv
// Scoreboard bench for sa_tile_framer: accepted input beats are framed by a
// reference model into an expected queue and matched against downstream beats.
module tb_sa_tile_framer;
  localparam int DW = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start_i;
  logic [15:0] cfg_k_i, cfg_nblocks_i, blocks_done_o;
  logic        busy_o, done_o, err_short_o;

  sa_tile_framer_if #(.DATA_WIDTH(DW)) bus ();

  sa_tile_framer #(.DATA_WIDTH(DW), .K_WIDTH(16), .NB_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start_i(cfg_start_i), .cfg_k_i(cfg_k_i),
    .cfg_nblocks_i(cfg_nblocks_i), .busy_o(busy_o), .done_o(done_o),
    .err_short_o(err_short_o), .blocks_done_o(blocks_done_o), .stream(bus)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total = 0;
  logic [DW-1:0] exp_q[$], obs_q[$];
  int cyc = 0, acc, occ = 0, done_cnt, done_cyc, start_cyc, first_pop, last_pop;
  int stall_viol, m_k, m_bc;
  logic overflow, full_drop_seen, rtr_seen, prev_stall;
  logic [DW-1:0] prev_data;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive inputs after negedge, then sample handshakes before posedge.
  task automatic step(input logic start, input logic rts, input logic eow,
                      input logic rtr, input logic [DW-1:0] d);
    logic push, pop, sob, eob;
    @(negedge clk);
    cfg_start_i = start; bus.rts_i = rts; bus.eow_dma_i = eow;
    bus.rtr_i = rtr; bus.data_i = d;
    #1;
    cyc++;
    push = bus.rts_i & bus.rtr_o;
    pop  = bus.rts_o & bus.rtr_i;
    if (bus.rtr_o && occ == 2) overflow = 1'b1;
    if (!bus.rtr_o && occ == 2) full_drop_seen = 1'b1;
    if (bus.rtr_o) rtr_seen = 1'b1;
    if (done_o) begin done_cnt++; done_cyc = cyc; end
    if (prev_stall && (bus.rts_o !== 1'b1 || bus.data_o !== prev_data)) stall_viol++;
    prev_stall = bus.rts_o & ~bus.rtr_i;
    prev_data  = bus.data_o;
    if (push) begin
      sob = (m_bc == 0);
      eob = (m_bc == m_k - 1) || eow;
      exp_q.push_back({eob, sob, d[DW-3:0]});
      m_bc = eob ? 0 : m_bc + 1;
      acc++;
    end
    if (pop) begin
      obs_q.push_back(bus.data_o);
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    occ = occ + int'(push) - int'(pop);
    if (occ > 2) overflow = 1'b1;
  endtask

  task automatic job_prep(input int k, input int nb);
    exp_q.delete(); obs_q.delete();
    done_cnt = 0; done_cyc = -1; acc = 0; first_pop = -1; last_pop = -1;
    stall_viol = 0; overflow = 1'b0; full_drop_seen = 1'b0; rtr_seen = 1'b0;
    prev_stall = 1'b0; m_k = (k == 0) ? 1 : k; m_bc = 0;
    cfg_k_i = 16'(k); cfg_nblocks_i = 16'(nb);
  endtask

  task automatic run_job(input int k, input int nb, input bit rts_rand,
                         input bit rtr_toggle, input int eow_beat, input bit clear_top);
    logic rts, rtr;
    logic [DW-1:0] d;
    job_prep(k, nb);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    start_cyc = cyc;
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      rts = rts_rand ? (i < 4 || $urandom_range(0, 3) != 0) : 1'b1;
      rtr = rtr_toggle ? (i % 2 == 0) : 1'b1;
      d = rand_data();
      if (clear_top) d[DW-1 -: 2] = 2'b00;
      step(1'b0, rts, rts && (acc == eow_beat), rtr, d);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else pass_cnt++;
    total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else pass_cnt++;
    total++; if (err_short_o !== 1'b0) $display("FAIL reset_err: got %b want 0", err_short_o); else pass_cnt++;
    total++; if (blocks_done_o !== 16'd0) $display("FAIL reset_blocks: got %0d want 0", blocks_done_o); else pass_cnt++;
    total++; if (bus.rtr_o !== 1'b0) $display("FAIL reset_rtr_o: got %b want 0", bus.rtr_o); else pass_cnt++;
    total++; if (bus.rts_o !== 1'b0) $display("FAIL reset_rts_o: got %b want 0", bus.rts_o); else pass_cnt++;
    total++; if (bus.data_o !== '0) $display("FAIL reset_data_o: got top %h low %h want 0", bus.data_o[DW-1 -: 8], bus.data_o[31:0]); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] e, o;
    logic [1:0] want;
    run_job(4, 2, 1'b0, 1'b0, -1, 1'b0);
    total++; if (obs_q.size() != 8) $display("FAIL basic_count: got %0d beats want 8", obs_q.size()); else pass_cnt++;
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL basic_beat%0d: got %h..%h want %h..%h", i, o[DW-1 -: 8], o[31:0], e[DW-1 -: 8], e[31:0]); else pass_cnt++;
      want = {(i % 4 == 3), (i % 4 == 0)};
      total++; if (o[DW-1 -: 2] !== want) $display("FAIL basic_flags%0d: got %b want %b", i, o[DW-1 -: 2], want); else pass_cnt++;
    end
    total++; if (blocks_done_o !== 16'd2) $display("FAIL basic_blocks: got %0d want 2", blocks_done_o); else pass_cnt++;
    total++; if (done_cnt != 1) $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    total++; if (done_cyc != last_pop + 1) $display("FAIL basic_done_time: got cycle %0d want %0d", done_cyc, last_pop + 1); else pass_cnt++;
    total++; if (last_pop - first_pop != 7) $display("FAIL basic_throughput: got span %0d want 7", last_pop - first_pop); else pass_cnt++;
    total++; if (err_short_o !== 1'b0) $display("FAIL basic_err: got %b want 0", err_short_o); else pass_cnt++;
  endtask

  task automatic test_k1();
    logic [DW-1:0] e, o;
    run_job(1, 3, 1'b0, 1'b0, -1, 1'b1);
    total++; if (obs_q.size() != 3) $display("FAIL k1_count: got %0d beats want 3", obs_q.size()); else pass_cnt++;
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL k1_beat%0d: got %h..%h want %h..%h", i, o[DW-1 -: 8], o[31:0], e[DW-1 -: 8], e[31:0]); else pass_cnt++;
      total++; if (o[DW-1 -: 2] !== 2'b11) $display("FAIL k1_flags%0d: got %b want 11", i, o[DW-1 -: 2]); else pass_cnt++;
    end
    total++; if (blocks_done_o !== 16'd3) $display("FAIL k1_blocks: got %0d want 3", blocks_done_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back_stall();
    logic [DW-1:0] e, o;
    run_job(4, 2, 1'b1, 1'b1, -1, 1'b0);
    total++; if (obs_q.size() != 8) $display("FAIL stall_count: got %0d beats want 8", obs_q.size()); else pass_cnt++;
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL stall_beat%0d: got %h..%h want %h..%h", i, o[DW-1 -: 8], o[31:0], e[DW-1 -: 8], e[31:0]); else pass_cnt++;
    end
    total++; if (stall_viol != 0) $display("FAIL stall_hold: got %0d unstable stalled cycles want 0", stall_viol); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL stall_overflow: got %b want 0", overflow); else pass_cnt++;
    total++; if (full_drop_seen !== 1'b1) $display("FAIL stall_rtr_drop: got %b want 1", full_drop_seen); else pass_cnt++;
    total++; if (blocks_done_o !== 16'd2) $display("FAIL stall_blocks: got %0d want 2", blocks_done_o); else pass_cnt++;
    total++; if (done_cnt != 1) $display("FAIL stall_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_short_window();
    logic [DW-1:0] e, o;
    logic [1:0] flags [7];
    flags = '{2'b01, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b10};
    run_job(4, 2, 1'b0, 1'b0, 2, 1'b0);
    total++; if (obs_q.size() != 7) $display("FAIL short_count: got %0d beats want 7", obs_q.size()); else pass_cnt++;
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0 && i < 7; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL short_beat%0d: got %h..%h want %h..%h", i, o[DW-1 -: 8], o[31:0], e[DW-1 -: 8], e[31:0]); else pass_cnt++;
      total++; if (o[DW-1 -: 2] !== flags[i]) $display("FAIL short_flags%0d: got %b want %b", i, o[DW-1 -: 2], flags[i]); else pass_cnt++;
    end
    total++; if (err_short_o !== 1'b1) $display("FAIL short_err: got %b want 1", err_short_o); else pass_cnt++;
    total++; if (blocks_done_o !== 16'd2) $display("FAIL short_blocks: got %0d want 2", blocks_done_o); else pass_cnt++;
    total++; if (done_cnt != 1) $display("FAIL short_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_k0_nb0();
    logic [DW-1:0] e, o;
    run_job(0, 2, 1'b0, 1'b0, -1, 1'b1);
    total++; if (obs_q.size() != 2) $display("FAIL k0_count: got %0d beats want 2", obs_q.size()); else pass_cnt++;
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL k0_beat%0d: got %h..%h want %h..%h", i, o[DW-1 -: 8], o[31:0], e[DW-1 -: 8], e[31:0]); else pass_cnt++;
      total++; if (o[DW-1 -: 2] !== 2'b11) $display("FAIL k0_flags%0d: got %b want 11", i, o[DW-1 -: 2]); else pass_cnt++;
    end
    total++; if (err_short_o !== 1'b0) $display("FAIL k0_err_cleared: got %b want 0", err_short_o); else pass_cnt++;
    total++; if (blocks_done_o !== 16'd2) $display("FAIL k0_blocks: got %0d want 2", blocks_done_o); else pass_cnt++;
    run_job(4, 0, 1'b0, 1'b0, -1, 1'b0);
    total++; if (done_cnt != 1) $display("FAIL nb0_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
    total++; if (done_cyc != start_cyc + 1) $display("FAIL nb0_done_time: got cycle %0d want %0d", done_cyc, start_cyc + 1); else pass_cnt++;
    total++; if (rtr_seen !== 1'b0) $display("FAIL nb0_rtr: got %b want 0", rtr_seen); else pass_cnt++;
    total++; if (obs_q.size() != 0) $display("FAIL nb0_beats: got %0d want 0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_reset_midjob();
    logic [DW-1:0] e, o;
    job_prep(4, 4);
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 50 && acc < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b1, rand_data());
    total++; if (acc != 6) $display("FAIL mid_accept: got %0d beats want 6", acc); else pass_cnt++;
    #1;
    rst_n = 1'b0; bus.rts_i = 1'b0; bus.eow_dma_i = 1'b0;
    #1;
    total++; if (bus.rts_o !== 1'b0) $display("FAIL mid_rts_o: got %b want 0", bus.rts_o); else pass_cnt++;
    total++; if (bus.rtr_o !== 1'b0) $display("FAIL mid_rtr_o: got %b want 0", bus.rtr_o); else pass_cnt++;
    total++; if (busy_o !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy_o); else pass_cnt++;
    total++; if (blocks_done_o !== 16'd0) $display("FAIL mid_blocks: got %0d want 0", blocks_done_o); else pass_cnt++;
    total++; if (bus.data_o !== '0) $display("FAIL mid_data_o: got top %h low %h want 0", bus.data_o[DW-1 -: 8], bus.data_o[31:0]); else pass_cnt++;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1; occ = 0;
    run_job(4, 2, 1'b0, 1'b0, -1, 1'b0);
    total++; if (obs_q.size() != 8) $display("FAIL post_count: got %0d beats want 8", obs_q.size()); else pass_cnt++;
    for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      total++; if (o !== e) $display("FAIL post_beat%0d: got %h..%h want %h..%h", i, o[DW-1 -: 8], o[31:0], e[DW-1 -: 8], e[31:0]); else pass_cnt++;
    end
    total++; if (blocks_done_o !== 16'd2) $display("FAIL post_blocks: got %0d want 2", blocks_done_o); else pass_cnt++;
    total++; if (done_cnt != 1) $display("FAIL post_done_cnt: got %0d want 1", done_cnt); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; cfg_start_i = 1'b0; cfg_k_i = '0; cfg_nblocks_i = '0;
    bus.rts_i = 1'b0; bus.eow_dma_i = 1'b0; bus.rtr_i = 1'b0; bus.data_i = '0;
    prev_stall = 1'b0; prev_data = '0;
    test_reset();
    test_basic();
    test_k1();
    test_back_to_back_stall();
    test_short_window();
    test_k0_nb0();
    test_reset_midjob();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
